// File: rtl/frame_stream_source_pkg.sv
// rtl/frame_stream_source_pkg.sv - shared FSM encoding and pixel width for the frame stream source
package frame_stream_source_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/frame_stream_source_rd_valid_pipe.sv
// rtl/frame_stream_source_rd_valid_pipe.sv - read-latency matched shift register carrying {rd, eol}
module frame_stream_source_rd_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_d,
  input  logic eol_d,
  output logic rd_q,
  output logic eol_q,
  output logic pending
);

  logic [DEPTH-1:0] rd_sr;
  logic [DEPTH-1:0] eol_sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_sr  <= '0;
      eol_sr <= '0;
    end else begin
      rd_sr[0]  <= rd_d;
      eol_sr[0] <= eol_d & rd_d;
      for (int i = 1; i < DEPTH; i++) begin
        rd_sr[i]  <= rd_sr[i-1];
        eol_sr[i] <= eol_sr[i-1];
      end
    end
  end

  assign rd_q    = rd_sr[DEPTH-1];
  assign eol_q   = eol_sr[DEPTH-1];
  assign pending = |rd_sr;

endmodule

// File: rtl/frame_stream_source.sv
// rtl/frame_stream_source.sv - raster-order pixel source reading one frame from a sync-read memory
module frame_stream_source
  import frame_stream_source_pkg::*;
#(
  parameter int WIDTH  = 17,
  parameter int HEIGHT = 17,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              pause_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [PIX_W-1:0]  mem_data_i,
  output logic [PIX_W-1:0]  data_o,
  output logic              valid_o,
  output logic              eol_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              col_last;
  logic              frame_last;
  logic              tap_rd;
  logic              tap_eol;
  logic              pipe_busy;

  assign col_last   = (col == COL_W'(WIDTH - 1));
  assign frame_last = col_last && (row == ROW_W'(HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DRAIN ends once the final pixel is on the output and nothing remains in flight
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_i) state_nxt = ST_STREAM;
      ST_STREAM: if (mem_rd_o && frame_last) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (valid_o && !pipe_busy) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_o   = (state == ST_STREAM) && !pause_i;
    mem_addr_o = mem_rd_o ? addr : '0;
    done_o     = (state == ST_DONE);
    busy_o     = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (state == ST_IDLE) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (mem_rd_o) begin
      addr <= addr + ADDR_W'(1);
      if (col_last) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  frame_stream_source_rd_valid_pipe #(
    .DEPTH (RD_LAT)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .rd_d    (mem_rd_o),
    .eol_d   (col_last),
    .rd_q    (tap_rd),
    .eol_q   (tap_eol),
    .pending (pipe_busy)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      eol_o   <= 1'b0;
    end else begin
      data_o  <= tap_rd ? mem_data_i : '0;
      valid_o <= tap_rd;
      eol_o   <= tap_rd & tap_eol;
    end
  end

endmodule

// File: doc/frame_stream_source.md
Name: frame_stream_source

Overview:
- Raster-order pixel source that feeds the row line-buffer chain: reads one WIDTH x HEIGHT 8-bit frame from a synchronous-read frame memory and emits it as a serial stream (data_o, valid_o).
- Emits done_o once after the last pixel of the frame, so downstream line buffers can flush their tails.
- Sits between the frame memory and the preparation buffers; it is the producing end of the data/done stream those buffers consume.

Parameters:
- WIDTH, 17, pixels per row (matches line-buffer DEPTH)
- HEIGHT, 17, rows per frame
- ADDR_W, 10, memory address width; WIDTH*HEIGHT must be <= 2^ADDR_W
- RD_LAT, 1, memory read latency in cycles (1..4)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- start_i  in  1  one-cycle pulse that launches a frame; ignored while busy_o=1
- pause_i  in  1  1 = issue no new memory read this cycle
- mem_rd_o  out  1  memory read strobe
- mem_addr_o  out  ADDR_W  linear read address, row*WIDTH+col
- mem_data_i  in  8  read data, valid RD_LAT cycles after the mem_rd_o cycle
- data_o  out  8  pixel out
- valid_o  out  1  data_o is valid
- eol_o  out  1  with valid_o: pixel is the last one of its row
- done_o  out  1  one-cycle end-of-frame pulse
- busy_o  out  1  1 from the cycle after start_i is accepted through the done_o cycle

Behaviour:
- Reset (rst=0 at a posedge): FSM to IDLE; all counters and the valid pipeline cleared; every output 0, mem_addr_o=0. Reset mid-frame aborts the frame: no done_o, and in-flight reads are discarded.
- FSM states:
  - IDLE: start_i=1 -> STREAM, with addr, col and row counters = 0.
  - STREAM: each cycle with pause_i=0, assert mem_rd_o with the current address, then advance. col wraps at WIDTH-1 and row increments. The read of address WIDTH*HEIGHT-1 goes to DRAIN. With pause_i=1: mem_rd_o=0 and counters hold.
  - DRAIN: no reads issued; stay until the valid pipeline is empty and the last pixel has been output -> DONE.
  - DONE: done_o=1 for exactly one cycle -> IDLE.
- Valid pipeline:
  - Shift register of depth RD_LAT carries rd flag and eol flag per issued read.
  - At the tap: data_o <= mem_data_i, valid_o <= 1, eol_o <= carried eol.
  - Latency from mem_rd_o to valid_o = RD_LAT+1 cycles.
  - pause_i does not stall the pipeline; reads already issued still emerge.
- done_o asserts the cycle after the final valid_o (valid_o and done_o never overlap).
- busy_o drops to 0 in the cycle after done_o. start_i in that cycle or later is accepted.
- start_i while busy_o=1 is ignored: no restart, no queuing.
- pause_i held through the whole frame stalls indefinitely with no timeout.
- pause_i during DRAIN or DONE has no effect.
- Address is a separate incrementing counter; no multiplier. Pixel count per frame is exactly WIDTH*HEIGHT.
- eol_o=1 only on pixels with col=WIDTH-1. The final pixel has eol_o=1.

Decomposition:
- Shared package: FSM state encoding (IDLE, STREAM, DRAIN, DONE) and the pixel width constant 8.
- One natural sub-module, rd_valid_pipe: RD_LAT-deep shift register carrying {rd, eol} with synchronous active-low clear.
- Counters and FSM stay in the top module.

Test Plan:
- Common setup: WIDTH=4, HEIGHT=3, RD_LAT=1; memory model returns addr[7:0].
- Nominal: start_i pulse -> mem_rd_o high 12 consecutive cycles with addr 0..11; valid_o 12 cycles carrying 0..11 starting 2 cycles after the first mem_rd_o; eol_o on values 3, 7, 11; done_o one cycle after value 11; busy_o low the next cycle.
- Pause: pause_i=1 for 3 cycles after addr 5 issued -> no mem_rd_o for 3 cycles; values 0..11 still appear once each, in order, with a 3-cycle gap in valid_o; done_o after 11.
- Ignored start: start_i pulsed again at pixel 6 -> stream is unaffected; exactly 12 pixels and one done_o.
- Reset mid-frame: rst=0 one cycle after addr 7 issued -> next cycle all outputs 0, no done_o; a new start_i produces 0..11 cleanly.
- Latency sweep: RD_LAT=3 -> first valid_o 4 cycles after the first mem_rd_o; done_o the cycle after the last pixel; back-to-back start_i right after busy_o falls gives a second identical frame.
